// File: rtl/fifo_pkg.sv
// Shared sizing for the single-clock FIFO.
// Every FIFO file imports these defaults.
package fifo_pkg;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEPTH          = 1 << DEF_ADDR_WIDTH;
endpackage

// File: rtl/sync_fifo_top_if.sv
// Producer/consumer bundle for sync_fifo_top.
// The FIFO is the slave; the environment is the master.
interface fifo_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   logic                  winc;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  rinc;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  full;
   logic                  empty;

   modport master (
      output winc, wdata, rinc,
      input  rdata, full, empty
   );

   modport slave (
      input  winc, wdata, rinc,
      output rdata, full, empty
   );
endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port,
// one asynchronous read port, no reset.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem_q [1 << ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_fifo_top.sv
// Single-clock show-ahead FIFO with full/empty flags.
// Pointers carry a wrap bit to tell full from empty.
module sync_fifo_top
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic  clk,
   input  logic  rst,
   fifo_if.slave bus
);
   localparam logic [ADDR_WIDTH:0] PTR_ONE =
      {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
   logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
   logic                  wr_en, rd_en;
   logic                  full, empty;
   logic [DATA_WIDTH-1:0] mem_rdata;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                  (wptr_q[ADDR_WIDTH-1:0] ==
                   rptr_q[ADDR_WIDTH-1:0]);

   // Requests are gated by pre-edge flags; reset masks both.
   always_comb begin
      wr_en  = bus.winc && !full && !rst;
      rd_en  = bus.rinc && !empty && !rst;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (rst) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (wr_en) begin
            wptr_d = wptr_q + PTR_ONE;
         end
         if (rd_en) begin
            rptr_d = rptr_q + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wptr_q[ADDR_WIDTH-1:0]),
      .wdata (bus.wdata),
      .raddr (rptr_q[ADDR_WIDTH-1:0]),
      .rdata (mem_rdata)
   );

   assign bus.rdata = empty ? '0 : mem_rdata;
   assign bus.full  = full;
   assign bus.empty = empty;
endmodule

// File: tb/tb_sync_fifo_top.sv
// Scoreboard bench for sync_fifo_top against
// a queue-based reference FIFO.
module tb_sync_fifo_top;
   localparam int DEPTH = 16;

   typedef struct packed {
      logic       empty;
      logic       full;
      logic [7:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;

   exp_t       exp_q[$];
   logic [7:0] ref_q[$];

   fifo_if bus ();

   sync_fifo_top dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name,
                        input logic [7:0] got,
                        input logic [7:0] want);
      n_checks++;
      if (got === want) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %02h want %02h (t=%0t)",
                  name, got, want, $time);
      end
   endtask

   // Reference: a plain queue bounded at DEPTH entries.
   task automatic ref_update(input logic r,
                             input logic w,
                             input logic [7:0] d,
                             input logic rd);
      int n;
      exp_t e;
      if (r) begin
         ref_q.delete();
      end else begin
         n = ref_q.size();
         if (rd && n > 0) void'(ref_q.pop_front());
         if (w && n < DEPTH) ref_q.push_back(d);
      end
      e.empty = (ref_q.size() == 0);
      e.full  = (ref_q.size() == DEPTH);
      e.rdata = e.empty ? 8'h00 : ref_q[0];
      exp_q.push_back(e);
   endtask

   task automatic step(input logic r,
                       input logic w,
                       input logic [7:0] d,
                       input logic rd);
      @(negedge clk);
      rst       = r;
      bus.winc  = w;
      bus.wdata = d;
      bus.rinc  = rd;
      @(posedge clk);
      ref_update(r, w, d, rd);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("empty", {7'd0, bus.empty}, {7'd0, e.empty});
            check("full", {7'd0, bus.full}, {7'd0, e.full});
            check("rdata", bus.rdata, e.rdata);
         end
      end
   end

   initial begin : stim
      int budget;
      logic [7:0] d;
      rst       = 1'b1;
      bus.winc  = 1'b0;
      bus.wdata = 8'h00;
      bus.rinc  = 1'b0;

      repeat (2) step(1'b1, 1'b1, 8'h77, 1'b0);

      for (int i = 1; i <= 20; i++)
         step(1'b0, 1'b1, 8'(i), 1'b0);

      for (int i = 0; i < 20; i++)
         step(1'b0, 1'b0, 8'h00, 1'b1);

      for (int i = 0; i < 5; i++)
         step(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
      for (int i = 0; i < 30; i++)
         step(1'b0, 1'b1, 8'h10 + 8'(i), 1'b1);

      for (int i = 0; i < 11; i++)
         step(1'b0, 1'b1, 8'hC0 + 8'(i), 1'b0);
      step(1'b0, 1'b1, 8'hEE, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      for (int i = 0; i < 17; i++)
         step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b1, 8'h3C, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);

      for (int i = 0; i < 7; i++)
         step(1'b0, 1'b1, 8'h70 + 8'(i), 1'b0);
      step(1'b1, 1'b1, 8'h99, 1'b1);
      step(1'b0, 1'b1, 8'h55, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);

      for (int i = 0; i < 400; i++) begin
         d = 8'($urandom);
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 99) < 55, d,
              $urandom_range(0, 99) < 45);
      end

      budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      @(posedge clk);
      check("drain", 8'(exp_q.size()), 8'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
